// File: rtl/branch_predict_resolve_unit_if.sv
// rtl/branch_predict_resolve_unit_if.sv - IF lookup, EX resolve and redirect/stat signals of the branch unit
interface branch_predict_resolve_unit_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic              if_valid;
  logic [XLEN-1:0]   if_pc;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              ex_valid;
  logic              jump;
  logic              branch;
  logic [2:0]        func3;
  logic [XLEN-1:0]   out1;
  logic [XLEN-1:0]   out2;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   ex_pc;
  logic              ex_pred_taken;
  logic [XLEN-1:0]   ex_pred_target;
  logic              redirect;
  logic [XLEN-1:0]   redirect_addr;
  logic              flush;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mispred_count;

  modport master (
    output if_valid, if_pc, ex_valid, jump, branch, func3, out1, out2,
           alu_result, ex_pc, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_addr, flush,
           br_count, mispred_count
  );

  modport slave (
    input  if_valid, if_pc, ex_valid, jump, branch, func3, out1, out2,
           alu_result, ex_pc, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_addr, flush,
           br_count, mispred_count
  );
endinterface

// File: rtl/branch_predict_resolve_unit.sv
// rtl/branch_predict_resolve_unit.sv - EX branch resolution with direct-mapped BTB, registered redirect and stats
module branch_predict_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int CNT_W       = 2,
  parameter int STAT_W      = 32
) (
  input logic clk,
  input logic reset,
  branch_predict_resolve_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0]   PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic             valid_mem  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_mem    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_mem [BTB_ENTRIES];
  logic [CNT_W-1:0] cnt_mem    [BTB_ENTRIES];

  logic              redirect_q;
  logic [XLEN-1:0]   redirect_addr_q;
  logic [STAT_W-1:0] br_count_q;
  logic [STAT_W-1:0] mispred_count_q;

  // Lookup reads the arrays before this cycle's EX write lands.
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[XLEN-1:IDX_W+2];
  assign if_hit = bus.if_valid & valid_mem[if_idx] & (tag_mem[if_idx] == if_tag);

  assign bus.pred_taken  = if_hit & cnt_mem[if_idx][CNT_W-1];
  assign bus.pred_target = if_hit ? target_mem[if_idx] : bus.if_pc + PC_STEP;

  logic             cond;
  logic             legal;
  logic             active;
  logic             taken;
  logic             update;
  logic             mispredict;
  logic [XLEN-1:0]  actual;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (bus.func3)
      3'b000:  cond = (bus.out1 == bus.out2);
      3'b001:  cond = (bus.out1 != bus.out2);
      3'b100:  cond = ($signed(bus.out1) < $signed(bus.out2));
      3'b101:  cond = ($signed(bus.out1) >= $signed(bus.out2));
      3'b110:  cond = (bus.out1 < bus.out2);
      3'b111:  cond = (bus.out1 >= bus.out2);
      default: legal = 1'b0;
    endcase
  end

  // Anything in EX while a redirect is out is on the squashed wrong path.
  assign active     = bus.ex_valid & (bus.jump | bus.branch) & ~redirect_q;
  assign taken      = bus.jump | (bus.branch & legal & cond);
  assign update     = active & (bus.jump | legal);
  assign actual     = taken ? bus.alu_result : bus.ex_pc + PC_STEP;
  assign mispredict = active & ((taken != bus.ex_pred_taken) |
                      (taken & bus.ex_pred_taken & (bus.alu_result != bus.ex_pred_target)));

  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign ex_tag = bus.ex_pc[XLEN-1:IDX_W+2];
  assign ex_hit = valid_mem[ex_idx] & (tag_mem[ex_idx] == ex_tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_mem[i] <= 1'b0;
        cnt_mem[i]   <= CNT_WNT;
      end
    end else if (update) begin
      if (ex_hit) begin
        if (taken && cnt_mem[ex_idx] != CNT_MAX)
          cnt_mem[ex_idx] <= cnt_mem[ex_idx] + CNT_ONE;
        else if (!taken && cnt_mem[ex_idx] != '0)
          cnt_mem[ex_idx] <= cnt_mem[ex_idx] - CNT_ONE;
      end else if (taken) begin
        valid_mem[ex_idx] <= 1'b1;
        cnt_mem[ex_idx]   <= bus.jump ? CNT_MAX : CNT_WT;
      end
    end
  end

  // Tag rewrite on a hit is a no-op, so hit and allocate share one write.
  always_ff @(posedge clk) begin
    if (update && taken) begin
      tag_mem[ex_idx]    <= ex_tag;
      target_mem[ex_idx] <= bus.alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_addr_q <= actual;
        mispred_count_q <= mispred_count_q + STAT_ONE;
      end
      if (active)
        br_count_q <= br_count_q + STAT_ONE;
    end
  end

  assign bus.redirect      = redirect_q;
  assign bus.flush         = redirect_q;
  assign bus.redirect_addr = redirect_addr_q;
  assign bus.br_count      = br_count_q;
  assign bus.mispred_count = mispred_count_q;
endmodule
